// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and flag controller for an asynchronous FIFO (write clock domain).
// Tracks the binary write address and its Gray pointer, and derives full, almost-full,
// fill level and a sticky overflow flag from the synchronized Gray read pointer.
//
// Ports:
//   wclk      in   write-domain clock, rising edge
//   wrst      in   asynchronous active-high reset
//   winc      in   write request, accepted only while wfull=0
//   wq2_rptr  in   Gray read pointer already synchronized into wclk
//   wovf_clr  in   clears the sticky overflow flag
//   wen       out  memory write strobe (combinational) = winc & ~wfull
//   waddr     out  memory write address (low bits of the binary write count)
//   wptr      out  registered Gray write pointer, sent to the read domain
//   wfull     out  registered full flag
//   wafull    out  registered almost-full flag (fill level >= AFULL_THRESH)
//   wlevel    out  registered fill level, 0..2^ADDRSIZE
//   wovf      out  registered sticky overflow flag
module wptr_full_ctrl #(
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int unsigned PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AFULL_LIM = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin_q,   wbin_d;
    logic [PW-1:0] wptr_q,   wptr_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q,  wfull_d;
    logic          wafull_q, wafull_d;
    logic          wovf_q,   wovf_d;

    logic          wr_ok_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] fill_s;
    logic [PW-1:0] full_cmp_s;

    // Gray-to-binary of the synchronized read pointer: each bit is the XOR of itself and all higher bits.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
    end

    // Next-state pointer, flag and level logic.
    always_comb begin
        wr_ok_s    = winc & ~wfull_q;
        wbin_d     = wbin_q + PW'(wr_ok_s);
        wptr_d     = (wbin_d >> 1) ^ wbin_d;
        // Full when the write pointer has lapped the read pointer: top two Gray bits inverted, rest equal.
        full_cmp_s = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        wfull_d    = (wptr_d == full_cmp_s);
        // Modulo subtraction gives the correct occupancy across pointer wrap.
        fill_s     = wbin_d - rbin_s;
        wlevel_d   = fill_s;
        wafull_d   = (fill_s >= AFULL_LIM);
        // A dropped write in the same cycle as a clear keeps the flag set.
        wovf_d     = (winc & wfull_q) | (wovf_q & ~wovf_clr);
    end

    // State registers.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign wen    = wr_ok_s;
    assign waddr  = wbin_q[ADDRSIZE-1:0];
    assign wptr   = wptr_q;
    assign wfull  = wfull_q;
    assign wafull = wafull_q;
    assign wlevel = wlevel_q;
    assign wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl: instance a uses the default threshold (12),
// instance b uses a threshold equal to the depth (16).
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b0;
    logic       winc_b = 1'b0;
    logic [4:0] wq2_rptr = '0;
    logic       wovf_clr = 1'b0;

    logic       a_wen, a_wfull, a_wafull, a_wovf;
    logic [3:0] a_waddr;
    logic [4:0] a_wptr, a_wlevel;
    logic       b_wen, b_wfull, b_wafull, b_wovf;
    logic [3:0] b_waddr;
    logic [4:0] b_wptr, b_wlevel;

    integer errors = 0;
    integer checks = 0;

    always #5 wclk = ~wclk;

    wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut_a (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr), .wovf_clr(wovf_clr),
        .wen(a_wen), .waddr(a_waddr), .wptr(a_wptr), .wfull(a_wfull), .wafull(a_wafull),
        .wlevel(a_wlevel), .wovf(a_wovf)
    );

    wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_THRESH(16)) dut_b (
        .wclk(wclk), .wrst(wrst), .winc(winc_b), .wq2_rptr(wq2_rptr), .wovf_clr(wovf_clr),
        .wen(b_wen), .waddr(b_waddr), .wptr(b_wptr), .wfull(b_wfull), .wafull(b_wafull),
        .wlevel(b_wlevel), .wovf(b_wovf)
    );

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        winc = 1'b0; winc_b = 1'b0; wovf_clr = 1'b0; wq2_rptr = '0;
        wrst = 1'b1;
        step();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        checks++; if ({a_waddr, a_wptr, a_wlevel} !== 14'd0) begin errors++; $display("FAIL reset_ptrs got addr=%0d ptr=%b lvl=%0d want 0", a_waddr, a_wptr, a_wlevel); end
        checks++; if ({a_wen, a_wfull, a_wafull, a_wovf} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {a_wen, a_wfull, a_wafull, a_wovf}); end
        wrst = 1'b0;
        winc = 1'b1;
        repeat (5) step();
        winc = 1'b0;
        checks++; if (a_waddr !== 4'd5) begin errors++; $display("FAIL pre_reset_addr got %0d want 5", a_waddr); end
        #3 wrst = 1'b1;
        #1;
        checks++; if ({a_waddr, a_wptr, a_wlevel} !== 14'd0) begin errors++; $display("FAIL async_reset_ptrs got addr=%0d ptr=%b lvl=%0d want 0", a_waddr, a_wptr, a_wlevel); end
        checks++; if ({a_wfull, a_wafull, a_wovf} !== 3'b0) begin errors++; $display("FAIL async_reset_flags got %b want 000", {a_wfull, a_wafull, a_wovf}); end
        step();
        wrst = 1'b0;
        winc = 1'b1;
        step();
        winc = 1'b0;
        checks++; if (a_waddr !== 4'd1) begin errors++; $display("FAIL first_write_addr got %0d want 1", a_waddr); end
        checks++; if (a_wptr !== 5'b00001) begin errors++; $display("FAIL first_write_ptr got %b want 00001", a_wptr); end
        checks++; if (a_wlevel !== 5'd1) begin errors++; $display("FAIL first_write_level got %0d want 1", a_wlevel); end
    endtask

    task automatic test_fill_to_full();
        do_reset();
        winc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            checks++; if (a_wlevel !== 5'(i)) begin errors++; $display("FAIL fill_level[%0d] got %0d want %0d", i, a_wlevel, i); end
            checks++; if (a_wafull !== (i >= 12)) begin errors++; $display("FAIL fill_afull[%0d] got %b want %b", i, a_wafull, i >= 12); end
            checks++; if (a_wfull !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, a_wfull, i == 16); end
        end
        checks++; if (a_wptr !== 5'b11000) begin errors++; $display("FAIL full_ptr got %b want 11000", a_wptr); end
        checks++; if (a_wen !== 1'b0) begin errors++; $display("FAIL full_wen got %b want 0", a_wen); end
        step();
        winc = 1'b0;
        checks++; if (a_waddr !== 4'd0) begin errors++; $display("FAIL ovf_addr got %0d want 0", a_waddr); end
        checks++; if (a_wptr !== 5'b11000) begin errors++; $display("FAIL ovf_ptr got %b want 11000", a_wptr); end
        checks++; if (a_wovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", a_wovf); end
        checks++; if (a_wlevel !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", a_wlevel); end
    endtask

    task automatic test_drain_release();
        wq2_rptr = 5'b00110;
        step();
        checks++; if (a_wfull !== 1'b0) begin errors++; $display("FAIL drain_full got %b want 0", a_wfull); end
        checks++; if (a_wlevel !== 5'd12) begin errors++; $display("FAIL drain_level got %0d want 12", a_wlevel); end
        checks++; if (a_wafull !== 1'b1) begin errors++; $display("FAIL drain_afull got %b want 1", a_wafull); end
        winc = 1'b1;
        step();
        winc = 1'b0;
        checks++; if (a_wlevel !== 5'd13) begin errors++; $display("FAIL drain_write_level got %0d want 13", a_wlevel); end
        checks++; if (a_waddr !== 4'd1) begin errors++; $display("FAIL drain_write_addr got %0d want 1", a_waddr); end
    endtask

    task automatic test_ovf_clear();
        wovf_clr = 1'b1;
        step();
        wovf_clr = 1'b0;
        checks++; if (a_wovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", a_wovf); end
        winc = 1'b1;
        repeat (3) step();
        checks++; if (a_wfull !== 1'b1) begin errors++; $display("FAIL refill_full got %b want 1", a_wfull); end
        checks++; if (a_wovf !== 1'b0) begin errors++; $display("FAIL refill_no_ovf got %b want 0", a_wovf); end
        wovf_clr = 1'b1;
        step();
        winc = 1'b0; wovf_clr = 1'b0;
        checks++; if (a_wovf !== 1'b1) begin errors++; $display("FAIL ovf_clr_collide got %b want 1", a_wovf); end
        checks++; if (a_waddr !== 4'd4) begin errors++; $display("FAIL ovf_clr_addr got %0d want 4", a_waddr); end
        checks++; if (a_wptr !== 5'b11110) begin errors++; $display("FAIL ovf_clr_ptr got %b want 11110", a_wptr); end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_bin;
        logic [4:0] prev_ptr;
        do_reset();
        exp_bin = '0;
        prev_ptr = '0;
        winc = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            // Reader sees the write pointer through two sync stages: the value from one edge earlier.
            step();
            exp_bin = exp_bin + 5'd1;
            wq2_rptr = prev_ptr;
            checks++; if (a_wptr !== gray(exp_bin)) begin errors++; $display("FAIL wrap_ptr[%0d] got %b want %b", i, a_wptr, gray(exp_bin)); end
            checks++; if ($countones(a_wptr ^ prev_ptr) != 1) begin errors++; $display("FAIL wrap_gray_step[%0d] got %b after %b want one bit change", i, a_wptr, prev_ptr); end
            checks++; if (a_waddr !== exp_bin[3:0]) begin errors++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, a_waddr, exp_bin[3:0]); end
            checks++; if (a_wfull !== 1'b0) begin errors++; $display("FAIL wrap_full[%0d] got %b want 0", i, a_wfull); end
            checks++; if (a_wlevel > 5'd2) begin errors++; $display("FAIL wrap_level[%0d] got %0d want 0..2", i, a_wlevel); end
            prev_ptr = a_wptr;
        end
        winc = 1'b0;
        checks++; if (exp_bin !== 5'd8 || a_wptr !== 5'b01100) begin errors++; $display("FAIL wrap_final_ptr got %b want 01100", a_wptr); end
    endtask

    task automatic test_thresh_edge();
        do_reset();
        winc_b = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            checks++; if (b_wafull !== (i == 16)) begin errors++; $display("FAIL thr_afull[%0d] got %b want %b", i, b_wafull, i == 16); end
            checks++; if (b_wfull !== (i == 16)) begin errors++; $display("FAIL thr_full[%0d] got %b want %b", i, b_wfull, i == 16); end
        end
        winc_b = 1'b0;
        checks++; if (b_wlevel !== 5'd16) begin errors++; $display("FAIL thr_level got %0d want 16", b_wlevel); end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_to_full();
        test_drain_release();
        test_ovf_clear();
        test_wrap();
        test_thresh_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
- Write-side pointer and flag controller for the asynchronous FIFO; counterpart of the read-pointer/empty logic.
- Runs entirely in the write clock domain.
- Keeps the binary write address and Gray write pointer; wptr goes to the read-domain 2-FF synchronizer.
- From the synchronized Gray read pointer it produces full, almost-full, a fill level and a sticky overflow flag.

Parameters:
- ADDRSIZE, 4, memory address width; FIFO depth = 2^ADDRSIZE.
- AFULL_THRESH, 12, wafull asserts when the fill level is >= this value; legal range 1..2^ADDRSIZE.

Ports:
- wclk  input  1  write-domain clock, rising edge.
- wrst  input  1  asynchronous, active-high reset.
- winc  input  1  write request; accepted only when wfull=0.
- wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already 2-FF synchronized into wclk.
- wovf_clr  input  1  clears the sticky overflow flag.
- wen  output  1  memory write strobe (combinational), = winc & ~wfull.
- waddr  output  ADDRSIZE  memory write address, = wbin[ADDRSIZE-1:0].
- wptr  output  ADDRSIZE+1  registered Gray write pointer.
- wfull  output  1  registered full flag.
- wafull  output  1  registered almost-full flag.
- wlevel  output  ADDRSIZE+1  registered fill level, 0..2^ADDRSIZE.
- wovf  output  1  sticky overflow flag, registered.

Behaviour:
- Reset (wrst=1, asynchronous, takes effect mid-cycle): wbin=0, wptr=0, wfull=0, wafull=0, wlevel=0, wovf=0. Outputs hold these values while wrst=1.
- Next-state pointer logic:
  - wbinnext = wbin + (winc & ~wfull), modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext>>1) ^ wbinnext.
  - On each wclk edge: wbin<=wbinnext, wptr<=wgraynext.
- Full flag:
  - wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull <= wfull_val. wfull rises on the same edge that registers the 2^ADDRSIZE-th outstanding write.
- Read-pointer conversion: rbin_s = Gray-to-binary of wq2_rptr (XOR prefix from MSB), combinational.
- Fill level:
  - wlevel <= wbinnext - rbin_s, computed modulo 2^(ADDRSIZE+1). Wrap-around yields the correct difference.
  - The result never exceeds 2^ADDRSIZE for a legal wq2_rptr.
- Almost-full: wafull <= (wbinnext - rbin_s) >= AFULL_THRESH, using the same registered timing as wlevel.
- Overflow:
  - If winc=1 and wfull=1 on an edge, the write is dropped: wbin, waddr and wptr are unchanged and wovf<=1.
  - wovf_clr=1 clears wovf, except that a simultaneous overflow event wins (wovf stays 1).
- Flag pessimism: wq2_rptr lags by 2+ cycles, so wfull, wafull and wlevel are conservative (may overstate fill).
  - wfull deasserts only on the first edge after wq2_rptr changes to show space.
  - No write is ever accepted into a full memory.
- wen is combinational from the registered wfull and live winc; it must match the bin increment exactly.
- Wrap-around: after 2^(ADDRSIZE+1) accepted writes, wbin and wptr return to 0. The MSB toggles every 2^ADDRSIZE writes.
- Only wptr crosses domains. wptr changes by exactly one Gray bit per accepted write.
- No combinational path from wq2_rptr to any output.

Test Plan:
- Reset: assert wrst mid-cycle with wbin=5 -> all outputs 0 immediately, without waiting for a clock edge. Release, winc=1 for 1 cycle -> waddr=1, wptr=5'b00001, wlevel=1.
- Fill to full (ADDRSIZE=4, wq2_rptr=0): 16 consecutive winc.
  - wafull=1 after write 12 (wlevel=12).
  - wfull=1 after write 16 (wlevel=16, wptr=5'b11000).
  - 17th winc -> wen=0, waddr stays 0, wovf=1.
- Drain release: from full, set wq2_rptr=Gray(4)=5'b00110 -> next edge wfull=0, wlevel=12, wafull=1. One more write -> wlevel=13.
- Overflow clear: wovf=1, pulse wovf_clr alone -> wovf=0. Pulse wovf_clr together with winc while full -> wovf stays 1.
- Wrap: 40 writes with the reader tracking 2 cycles behind -> no spurious wfull.
  - wptr sequence is Gray with single-bit steps.
  - wbin wraps 31->0.
  - wlevel stays 0..2 throughout.
- Threshold edge: AFULL_THRESH=16 -> wafull and wfull assert on the same edge.
